// File: rtl/uart_ctrl.sv
// uart_ctrl: 8N1 UART transmitter/receiver with a one-byte RX holding register.
module uart_ctrl #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_we,
    output logic       tx_busy,
    input  logic       rx_re,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_overrun,
    output logic       rx_frame_err,
    output logic       uart_txd,
    input  logic       uart_rxd
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        tx_state, tx_next, rx_state, rx_next;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic [2:0]    tx_idx, rx_idx;
    logic [7:0]    tx_shift, rx_shift;
    logic          rx_s1, rx_s2;
    logic          tx_tick, rx_tick, rx_mid, rx_done;

    assign tx_tick  = tx_cnt == LAST;
    assign rx_tick  = rx_cnt == LAST;
    assign rx_mid   = rx_cnt == HALF;
    assign rx_done  = rx_state == STOP && rx_tick;
    assign tx_busy  = tx_state != IDLE;
    assign uart_txd = tx_state == START ? 1'b0 : tx_state == DATA ? tx_shift[0] : 1'b1;

    always_comb begin
        tx_next = tx_state;
        unique case (tx_state)
            IDLE:    if (tx_we) tx_next = START;
            START:   if (tx_tick) tx_next = DATA;
            DATA:    if (tx_tick && tx_idx == 3'd7) tx_next = STOP;
            STOP:    if (tx_tick) tx_next = IDLE;
            default: tx_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_next;
            tx_cnt   <= (tx_state == IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
            if (tx_state == IDLE && tx_we) tx_shift <= tx_data;
            if (tx_state == DATA && tx_tick) begin
                tx_shift <= tx_shift >> 1;
                tx_idx   <= tx_idx + 1'b1;
            end
        end
    end

    // A start bit that is high again at its centre is treated as a glitch.
    always_comb begin
        rx_next = rx_state;
        unique case (rx_state)
            IDLE:    if (!rx_s2) rx_next = START;
            START:   if (rx_mid) rx_next = rx_s2 ? IDLE : DATA;
            DATA:    if (rx_tick && rx_idx == 3'd7) rx_next = STOP;
            STOP:    if (rx_tick) rx_next = IDLE;
            default: rx_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1        <= 1'b1;
            rx_s2        <= 1'b1;
            rx_state     <= IDLE;
            rx_cnt       <= '0;
            rx_idx       <= '0;
            rx_shift     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_s1        <= uart_rxd;
            rx_s2        <= rx_s1;
            rx_state     <= rx_next;
            rx_cnt       <= (rx_state == IDLE || rx_tick || (rx_state == START && rx_mid)) ? '0 : rx_cnt + 1'b1;
            rx_overrun   <= rx_done && rx_s2 && rx_valid && !rx_re;
            rx_frame_err <= rx_done && !rx_s2;
            if (rx_state == DATA && rx_tick) begin
                rx_shift <= {rx_s2, rx_shift[7:1]};
                rx_idx   <= rx_idx + 1'b1;
            end
            if (rx_done && rx_s2) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (rx_re) begin
                rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: directed checks of uart_ctrl TX/RX framing, overrun, framing error and reset.
module tb_uart_ctrl;
    localparam int CPB = 16;

    logic       clk = 0, rst = 1, tx_we = 0, rx_re = 0, rxd_drv = 1, loop = 0;
    logic [7:0] tx_data = '0;
    logic [7:0] mid_b = 8'h99;
    logic       tx_busy, rx_valid, rx_overrun, rx_frame_err, uart_txd, uart_rxd;
    logic [7:0] rx_data;
    int         checks = 0, errors = 0, ovr_cnt = 0, ferr_cnt = 0;
    int         ovr0, ferr0;
    logic       done;

    assign uart_rxd = loop ? uart_txd : rxd_drv;

    uart_ctrl #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_we(tx_we), .tx_busy(tx_busy),
        .rx_re(rx_re), .rx_data(rx_data), .rx_valid(rx_valid), .rx_overrun(rx_overrun),
        .rx_frame_err(rx_frame_err), .uart_txd(uart_txd), .uart_rxd(uart_rxd)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_overrun) ovr_cnt++;
        if (rx_frame_err) ferr_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tx_frame(input logic [7:0] d, input int inj);
        int   k;
        logic b;
        tx_data = d;
        tx_we   = 1;
        tick;
        tx_we = 0;
        for (int i = 0; i < 10 * CPB; i++) begin
            k = i / CPB;
            b = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : d[k-1];
            check($sformatf("tx_bit%0d_c%0d", k, i), uart_txd, b);
            check($sformatf("tx_busy_c%0d", i), tx_busy, 1);
            tx_we = (i == inj);
            if (i == inj) tx_data = 8'h3C;
            tick;
        end
        tx_we = 0;
        check("tx_busy_fall", tx_busy, 0);
        check("tx_idle_txd", uart_txd, 1);
        repeat (20) tick;
        check("tx_no_second_frame", tx_busy, 0);
        check("tx_no_second_txd", uart_txd, 1);
    endtask

    task automatic rx_send(input logic [7:0] d, input logic stop, input int re_at, input bit lat);
        int k;
        for (int i = 0; i < 10 * CPB; i++) begin
            k = i / CPB;
            rxd_drv = (k == 0) ? 1'b0 : (k == 9) ? stop : d[k-1];
            rx_re = (i == re_at);
            if (lat && i == 154) check("rx_lat_early", rx_valid, 0);
            if (lat && i == 155) check("rx_lat", rx_valid, 1);
            tick;
        end
        rxd_drv = 1;
        rx_re   = 0;
        repeat (20) tick;
    endtask

    initial begin
        repeat (3) tick;
        check("rst_txd", uart_txd, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_ovr", rx_overrun, 0);
        check("rst_ferr", rx_frame_err, 0);
        rst = 0;
        repeat (5) tick;

        tx_frame(8'hA5, -1);
        tx_frame(8'hA5, 50);

        rx_send(8'h3C, 1, -1, 1);
        check("rx_good_valid", rx_valid, 1);
        check("rx_good_data", rx_data, 8'h3C);
        rx_re = 1;
        tick;
        rx_re = 0;
        check("rx_re_valid", rx_valid, 0);
        check("rx_re_data", rx_data, 8'h3C);
        rx_re = 1;
        tick;
        rx_re = 0;
        check("rx_re_empty_valid", rx_valid, 0);

        ovr0 = ovr_cnt; ferr0 = ferr_cnt;
        rxd_drv = 0;
        repeat (4) tick;
        rxd_drv = 1;
        repeat (30) tick;
        check("glitch_valid", rx_valid, 0);
        check("glitch_data", rx_data, 8'h3C);
        check("glitch_ovr", ovr_cnt - ovr0, 0);
        check("glitch_ferr", ferr_cnt - ferr0, 0);

        ovr0 = ovr_cnt; ferr0 = ferr_cnt;
        rx_send(8'h55, 0, -1, 0);
        check("ferr_pulse", ferr_cnt - ferr0, 1);
        check("ferr_valid", rx_valid, 0);
        check("ferr_data", rx_data, 8'h3C);
        check("ferr_ovr", ovr_cnt - ovr0, 0);

        ovr0 = ovr_cnt;
        rx_send(8'h11, 1, -1, 1);
        check("ovr_first_data", rx_data, 8'h11);
        check("ovr_first_pulse", ovr_cnt - ovr0, 0);
        rx_send(8'h22, 1, -1, 0);
        check("ovr_pulse", ovr_cnt - ovr0, 1);
        check("ovr_data", rx_data, 8'h22);
        check("ovr_valid", rx_valid, 1);

        rx_re = 1;
        tick;
        rx_re = 0;
        rx_send(8'h11, 1, -1, 1);
        ovr0 = ovr_cnt;
        rx_send(8'h22, 1, 154, 0);
        check("race_ovr", ovr_cnt - ovr0, 0);
        check("race_data", rx_data, 8'h22);
        check("race_valid", rx_valid, 1);

        tx_data = 8'hF0;
        tx_we   = 1;
        for (int i = 0; i < 84; i++) begin
            rxd_drv = (i / CPB == 0) ? 1'b0 : mid_b[i/CPB-1];
            tick;
            tx_we = 0;
        end
        check("pre_rst_busy", tx_busy, 1);
        rst = 1;
        tick;
        rst = 0;
        rxd_drv = 1;
        check("mid_rst_txd", uart_txd, 1);
        check("mid_rst_busy", tx_busy, 0);
        check("mid_rst_valid", rx_valid, 0);
        check("mid_rst_data", rx_data, 0);
        repeat (20) tick;

        loop    = 1;
        tx_data = 8'h81;
        tx_we   = 1;
        tick;
        tx_we = 0;
        done  = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (!tx_busy) done = 1;
            else tick;
        end
        check("rt_busy_drop", done, 1);
        repeat (10) tick;
        check("rt_valid", rx_valid, 1);
        check("rt_data", rx_data, 8'h81);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_ctrl.md
Name: uart_ctrl

Overview:
- Byte-level UART serializer/deserializer on the core's memory-mapped UART port.
- Consumes the core's tx_data/tx_we/rx_re strobes; returns rx_data/rx_valid/tx_busy.
- Drives the FPGA TX pin and samples the RX pin.
- Fixed 8N1 framing, LSB first, one-byte RX holding register.

Parameters:
CLKS_PER_BIT, 868, clock cycles per bit period (100 MHz / 115200); legal range ≥ 8; bench uses 16.

Ports:
clk  input  1  system clock; single clock domain.
rst  input  1  synchronous, active-high reset.
tx_data  input  8  byte to transmit; sampled only on an accepted tx_we.
tx_we  input  1  single-cycle transmit request.
tx_busy  output  1  high while a frame is in flight.
rx_re  input  1  single-cycle read strobe; consumes the held byte.
rx_data  output  8  last received byte.
rx_valid  output  1  held byte not yet consumed.
rx_overrun  output  1  one-cycle pulse: a completed byte replaced an unconsumed one.
rx_frame_err  output  1  one-cycle pulse: stop bit sampled low.
uart_txd  output  1  serial out; idle high.
uart_rxd  input  1  serial in; asynchronous.

Behaviour:
Reset:
- Sync reset: uart_txd=1, tx_busy=0, rx_valid=0, rx_data=0, both pulses=0, both FSMs IDLE, counters 0, synchronizer flops=1.
- Reset mid-frame aborts the frame; uart_txd is 1 after the reset edge.

TX FSM (IDLE→START→DATA→STOP→IDLE):
- IDLE: tx_we=1 with tx_busy=0 latches tx_data.
- Next edge: tx_busy=1, uart_txd=0 (START).
- Each state lasts CLKS_PER_BIT cycles, counted by a bit counter 0..CLKS_PER_BIT-1.
- DATA: shifts out bits 0..7, index counter 0..7.
- STOP: uart_txd=1.
- tx_busy is high for exactly 10*CLKS_PER_BIT cycles, then drops. A new tx_we is accepted the same cycle tx_busy reads 0.
- tx_we while tx_busy=1 is ignored: no queueing, and tx_data is not re-sampled.

RX path:
- uart_rxd passes through a 2-flop synchronizer; all RX logic uses the synchronized value.
- IDLE: synchronized 0 → START, counter cleared.
- START: at count CLKS_PER_BIT/2 - 1 (mid start bit), re-sample. 1 → back to IDLE (glitch reject, no pulse). 0 → DATA, counter cleared.
- DATA: sample at every CLKS_PER_BIT count (bit centres) into the shift register, LSB first; after 8 samples → STOP.
- STOP: sample after CLKS_PER_BIT.
  - Sample 1: rx_data←shift register and rx_valid=1 on the next edge. If rx_valid was already 1 and rx_re is not asserted that cycle, rx_overrun pulses; the new byte overwrites.
  - Sample 0: rx_frame_err pulses, byte discarded, rx_valid/rx_data unchanged.
  - Either way → IDLE; a new start bit is detectable the following cycle.

rx_re handling:
- rx_re with rx_valid=1: rx_valid=0 next edge; rx_data holds its value.
- rx_re with rx_valid=0: no effect.
- rx_re in the same cycle a byte completes: the new byte wins (rx_valid stays 1, rx_data=new), no overrun.

Concurrency:
- TX and RX are fully independent; a simultaneous TX accept and RX completion both take effect.

Test Plan:
- CLKS_PER_BIT=16, TX: tx_we with tx_data=0xA5 from idle → tx_busy rises next edge. uart_txd sequence 0,1,0,1,0,0,1,0,1,1, each held 16 cycles. tx_busy falls after exactly 160 cycles.
- TX busy rejection: second tx_we with 0x3C at cycle 50 of the 0xA5 frame → serial stream is unchanged 0xA5; no second frame follows.
- RX good byte: drive frame for 0x3C at 16 cycles/bit → rx_valid=1, rx_data=0x3C within 3 cycles after stop-bit centre (synchronizer plus register). Then rx_re → rx_valid=0 next cycle, rx_data still 0x3C.
- RX glitch and framing:
  - 4-cycle low pulse on uart_rxd → no state change, no pulses.
  - Frame 0x55 with stop bit 0 → one-cycle rx_frame_err; rx_valid stays 0.
- RX overrun: receive 0x11 and leave it unread, then receive 0x22 → one-cycle rx_overrun, rx_data=0x22, rx_valid=1. Repeat with rx_re asserted on the completion cycle → no overrun, rx_data=0x22.
- Reset mid-frame: rst at bit 4 of a TX frame and mid-RX byte → next cycle uart_txd=1, tx_busy=0, rx_valid=0. A subsequent 0x81 TX/RX round-trip (txd looped to rxd) yields rx_data=0x81.
